// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction fetch path: opcode field geometry and
// the fetch FSM state encoding.
package riscv_pkg;

  localparam int OPCODE_W = 12;
  localparam int OPC_LSB  = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: reset value, sequential increment and redirect load.
// A load wins over an increment issued in the same cycle.
module fetch_pc_reg #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_pc,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] PC_STEP = 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_pc;
    end else if (inc) begin
      pc <= pc + PC_STEP;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding word read to instruction memory,
// single-entry instruction buffer toward decode, redirect from the branch path.
//
//   state | meaning
//   IDLE  | stopped, no request outstanding, buffer empty
//   FETCH | imem_req high, waiting for the response to imem_addr
//   HOLD  | buffer full, id_valid high until decode accepts it
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 32,
  parameter int                OPC_LSB  = riscv_pkg::OPC_LSB,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                imem_rvalid,
  input  logic                redirect,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic                id_valid,
  input  logic                id_ready,
  output logic [INSTR_W-1:0]  id_instr,
  output logic [OPCODE_W-1:0] id_opcode,
  output logic [ADDR_W-1:0]   id_pc
);

  fetch_state_e      state;
  logic              kill;
  logic              accept;
  logic              handshake;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] issue_pc;

  assign accept    = (state == FETCH) && imem_rvalid && !kill && !redirect;
  assign handshake = id_valid && id_ready;
  assign issue_pc  = redirect ? redirect_pc : pc;
  assign id_opcode = id_instr[OPC_LSB +: OPCODE_W];

  fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (accept),
    .load    (redirect),
    .load_pc (redirect_pc),
    .pc      (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      kill      <= 1'b0;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      id_valid  <= 1'b0;
      id_instr  <= '0;
      id_pc     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en && !redirect) begin
            state     <= FETCH;
            imem_req  <= 1'b1;
            imem_addr <= pc;
          end
        end
        FETCH: begin
          if (imem_rvalid) begin
            if (kill || redirect) begin
              // stale response: drop it and reissue at the current target
              kill      <= 1'b0;
              imem_addr <= issue_pc;
            end else begin
              id_instr  <= imem_rdata;
              id_pc     <= imem_addr;
              id_valid  <= 1'b1;
              imem_req  <= 1'b0;
              state     <= HOLD;
            end
          end else if (redirect) begin
            kill <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect) begin
            id_valid  <= 1'b0;
            state     <= FETCH;
            imem_req  <= 1'b1;
            imem_addr <= redirect_pc;
          end else if (handshake) begin
            id_valid <= 1'b0;
            if (en) begin
              state     <= FETCH;
              imem_req  <= 1'b1;
              imem_addr <= pc;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by randomized traffic, with a
// variable-latency memory model and a program-order scoreboard on the decode side.
module tb_fetch_unit;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 32;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               en = 1'b0;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata = '0;
  logic               imem_rvalid = 1'b0;
  logic               redirect = 1'b0;
  logic [ADDR_W-1:0]  redirect_pc = '0;
  logic               id_valid;
  logic               id_ready = 1'b0;
  logic [INSTR_W-1:0] id_instr;
  logic [11:0]        id_opcode;
  logic [ADDR_W-1:0]  id_pc;

  fetch_unit #(
    .ADDR_W   (ADDR_W),
    .INSTR_W  (INSTR_W),
    .OPC_LSB  (20),
    .RESET_PC (16'h0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_rvalid (imem_rvalid),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_instr    (id_instr),
    .id_opcode   (id_opcode),
    .id_pc       (id_pc)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // memory model and scoreboard state
  logic              busy = 1'b0;
  int                cnt = 0;
  logic [ADDR_W-1:0] raddr = '0;
  int                mem_lat = 1;
  logic              nx_en = 1'b0, nx_ready = 1'b0, nx_redirect = 1'b0;
  logic [ADDR_W-1:0] nx_rpc = '0;
  logic [ADDR_W-1:0] exp_pc = '0;
  logic              held = 1'b0;
  logic [INSTR_W-1:0] held_instr = '0;
  logic [ADDR_W-1:0] held_pc = '0;
  int                n_hs = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    if (a < 16'd2) return {a[3:0], 28'h0};
    return {a, ~a} ^ 32'h5A5A_0F0F;
  endfunction

  // One clock: at the falling edge run the memory, apply the next inputs and
  // score whatever decode will see at the coming rising edge.
  task automatic tick();
    logic [31:0] w;
    @(negedge clk);
    if (held) begin
      chk("hold_valid", id_valid, 1);
      chk("hold_instr", id_instr, held_instr);
      chk("hold_pc", id_pc, held_pc);
      held = 1'b0;
    end
    imem_rvalid = 1'b0;
    if (busy) begin
      chk("req_held", imem_req, 1);
      chk("addr_stable", imem_addr, raddr);
      cnt--;
      if (cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(raddr);
        busy        = 1'b0;
      end
    end else if (imem_req) begin
      busy  = 1'b1;
      raddr = imem_addr;
      cnt   = (mem_lat == 0) ? int'($urandom_range(1, 3)) : mem_lat;
    end
    chk("valid_req_excl", id_valid & imem_req, 0);
    en          = nx_en;
    id_ready    = nx_ready;
    redirect    = nx_redirect;
    redirect_pc = nx_rpc;
    if (redirect) begin
      exp_pc = redirect_pc;
    end else if (id_valid && id_ready) begin
      w = mem_word(id_pc);
      chk("sb_pc", id_pc, exp_pc);
      chk("sb_instr", id_instr, w);
      chk("sb_opcode", id_opcode, w[31:20]);
      exp_pc = exp_pc + 16'd1;
      n_hs++;
    end else if (id_valid) begin
      held       = 1'b1;
      held_instr = id_instr;
      held_pc    = id_pc;
    end
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!id_valid && k < 40) begin
      tick();
      k++;
    end
    chk(tag, id_valid, 1);
  endtask

  task automatic consume();
    nx_ready = 1'b1;
    tick();
    nx_ready = 1'b0;
    tick();
  endtask

  initial begin
    #3;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", id_valid, 0);
    chk("rst_instr", id_instr, 0);
    chk("rst_pc", id_pc, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: first two fetches from reset, 1-cycle memory
    nx_en = 1'b1;
    wait_valid("t1a_wait");
    chk("t1a_opcode", id_opcode, 12'h000);
    chk("t1a_pc", id_pc, 16'h0000);
    consume();
    wait_valid("t1b_wait");
    chk("t1b_opcode", id_opcode, 12'h100);
    chk("t1b_pc", id_pc, 16'h0001);

    // 2: backpressure in HOLD
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_valid", id_valid, 1);
      chk("t2_instr", id_instr, 32'h1000_0000);
      chk("t2_pc", id_pc, 16'h0001);
      chk("t2_req", imem_req, 0);
    end

    // 3: redirect while the fetch of @2 is outstanding, 3-cycle memory
    mem_lat = 3;
    consume();
    chk("t3_req", imem_req, 1);
    chk("t3_addr2", imem_addr, 16'h0002);
    nx_redirect = 1'b1;
    nx_rpc = 16'h0040;
    tick();
    nx_redirect = 1'b0;
    begin
      int k = 0;
      while (imem_addr == 16'h0002 && k < 20) begin
        tick();
        k++;
      end
    end
    chk("t3_next_addr", imem_addr, 16'h0040);
    wait_valid("t3_wait");
    chk("t3_pc", id_pc, 16'h0040);
    chk("t3_instr", id_instr, mem_word(16'h0040));

    // 4: redirect in HOLD together with a handshake flushes the buffer
    mem_lat = 1;
    nx_ready = 1'b1;
    nx_redirect = 1'b1;
    nx_rpc = 16'h0080;
    tick();
    nx_ready = 1'b0;
    nx_redirect = 1'b0;
    tick();
    chk("t4_valid", id_valid, 0);
    chk("t4_req", imem_req, 1);
    chk("t4_addr", imem_addr, 16'h0080);
    wait_valid("t4_wait");
    chk("t4_pc", id_pc, 16'h0080);

    // 5: PC wraps from the top of the address space
    nx_redirect = 1'b1;
    nx_rpc = 16'hFFFF;
    tick();
    nx_redirect = 1'b0;
    tick();
    wait_valid("t5_wait");
    chk("t5_pc", id_pc, 16'hFFFF);
    consume();
    chk("t5_addr", imem_addr, 16'h0000);
    wait_valid("t5b_wait");
    consume();
    chk("t6_pre_addr", imem_addr, 16'h0001);

    // 6: asynchronous reset in the middle of a fetch
    #2 rst_n = 1'b0;
    #1;
    chk("t6_req", imem_req, 0);
    chk("t6_addr", imem_addr, 0);
    chk("t6_valid", id_valid, 0);
    chk("t6_instr", id_instr, 0);
    chk("t6_opcode", id_opcode, 0);
    chk("t6_pc", id_pc, 0);
    busy = 1'b0;
    held = 1'b0;
    imem_rvalid = 1'b0;
    exp_pc = 16'h0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    begin
      int k = 0;
      while (!imem_req && k < 10) begin
        tick();
        k++;
      end
    end
    chk("t6_first_req", imem_req, 1);
    chk("t6_first_addr", imem_addr, 16'h0000);

    // randomized traffic, scored against program order
    mem_lat = 0;
    n_hs = 0;
    for (int i = 0; i < 3000; i++) begin
      nx_en       = ($urandom_range(0, 9) != 0);
      nx_ready    = ($urandom_range(0, 2) != 0);
      nx_redirect = ($urandom_range(0, 24) == 0);
      nx_rpc      = ($urandom_range(0, 3) == 0) ? 16'hFFFE + 16'($urandom_range(0, 1))
                                                : 16'($urandom);
      tick();
    end
    chk("rand_progress", (n_hs > 200) ? 32'd1 : 32'd0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
